// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator processor.
// Owns the PC, fetches instruction words over req/ack and issues one-cycle enables.
module instr_sequencer #(
  parameter int         ADDR_W    = 5,
  parameter logic [3:0] HALT_CODE = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              flag_z,
  output logic [3:0]        instr_code,
  output logic [7:0]        imm_data,
  output logic              load_en,
  output logic              store_en,
  output logic              R0_ce,
  output logic              R1_ce,
  output logic              R0_oe,
  output logic              R1_oe,
  output logic              alu_en,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  // state  | meaning
  // IDLE   | after reset, waiting for run
  // FETCH  | mem_req high at pc until mem_ack
  // DECODE | instruction register drives code/data/read selects
  // EXEC   | one action pulse, pc update
  // HALT   | stopped; run restarts from address 0
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] C_LOAD  = 4'hA;
  localparam logic [3:0] C_STORE = 4'hB;
  localparam logic [3:0] C_NOP   = 4'hC;
  localparam logic [3:0] C_JMP   = 4'hD;
  localparam logic [3:0] C_JZ    = 4'hE;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [15:0]       r_ir;
  logic [15:0]       w_ir_nxt;
  logic              r_err;
  logic              w_err_nxt;

  logic [3:0]        w_code;
  logic [1:0]        w_sel;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_unused;

  assign w_code   = r_ir[11:8];
  assign w_sel    = r_ir[13:12];
  assign w_target = r_ir[ADDR_W-1:0];
  assign w_pc_inc = r_pc + ADDR_W'(1);
  // Word bits [15:14] carry no meaning for this controller.
  assign w_unused = ^r_ir[15:14];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_err_nxt   = r_err;
    load_en     = 1'b0;
    store_en    = 1'b0;
    R0_ce       = 1'b0;
    R1_ce       = 1'b0;
    alu_en      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          w_ir_nxt    = mem_rdata;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = w_pc_inc;
        // HALT_CODE is tested first so it wins even if it aliases another code.
        if (w_code == HALT_CODE) begin
          w_state_nxt = S_HALT;
          w_pc_nxt    = r_pc;
        end else begin
          case (w_code)
            C_LOAD:  load_en = 1'b1;
            C_STORE: begin
              case (w_sel)
                2'b01: begin
                  store_en = 1'b1;
                  R0_ce    = 1'b1;
                end
                2'b10: begin
                  store_en = 1'b1;
                  R1_ce    = 1'b1;
                end
                default: w_err_nxt = 1'b1;
              endcase
            end
            C_NOP:   ;
            C_JMP:   w_pc_nxt = w_target;
            C_JZ:    if (flag_z) w_pc_nxt = w_target;
            default: alu_en = 1'b1;
          endcase
        end
      end
      S_HALT: begin
        if (run) begin
          w_pc_nxt    = '0;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_req    = (r_state == S_FETCH);
  assign mem_addr   = r_pc;
  assign pc         = r_pc;
  assign instr_code = w_code;
  assign imm_data   = r_ir[7:0];
  assign R0_oe      = ((r_state == S_DECODE) || (r_state == S_EXEC)) && r_ir[12];
  assign R1_oe      = ((r_state == S_DECODE) || (r_state == S_EXEC)) && r_ir[13];
  assign busy       = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
  assign halted     = (r_state == S_HALT);
  assign err        = r_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer against an instruction-level reference model.
module tb_instr_sequencer;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic              flag_z;
  logic [3:0]        instr_code;
  logic [7:0]        imm_data;
  logic              load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe, alu_en;
  logic [ADDR_W-1:0] pc;
  logic              busy, halted, err;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flag_z(flag_z), .instr_code(instr_code), .imm_data(imm_data),
    .load_en(load_en), .store_en(store_en), .R0_ce(R0_ce), .R1_ce(R1_ce),
    .R0_oe(R0_oe), .R1_oe(R1_oe), .alu_en(alu_en),
    .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] prog [DEPTH];
  int m_pc;
  bit m_err;
  bit m_halted;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // {load_en, store_en, R0_ce, R1_ce, alu_en} expected in the EXEC cycle
  function automatic logic [4:0] exp_pulses(input logic [15:0] w);
    logic [3:0] code;
    logic [1:0] sel;
    code = w[11:8];
    sel  = w[13:12];
    if (code == 4'hF) return 5'b00000;
    case (code)
      4'hA: return 5'b10000;
      4'hB: begin
        if (sel == 2'b01) return 5'b01100;
        if (sel == 2'b10) return 5'b01010;
        return 5'b00000;
      end
      4'hC, 4'hD, 4'hE: return 5'b00000;
      default: return 5'b00001;
    endcase
  endfunction

  function automatic int next_pc(input logic [15:0] w, input int cur, input bit fz);
    int tgt;
    tgt = int'(w[7:0]) % DEPTH;
    case (w[11:8])
      4'hD: return tgt;
      4'hE: return fz ? tgt : (cur + 1) % DEPTH;
      4'hF: return cur;
      default: return (cur + 1) % DEPTH;
    endcase
  endfunction

  // Entered at a negedge while the DUT is in FETCH; returns after EXEC.
  // noise: 0 quiet, 1 run and mem_ack forced high while busy after fetch, 2 random.
  task automatic exec_instr(input int wait_n, input bit fz, input int noise);
    logic [15:0] w;
    w = prog[m_pc];
    check_eq("fetch_req", {31'd0, mem_req}, 1);
    check_eq("fetch_addr", {27'd0, mem_addr}, m_pc);
    for (int i = 0; i < wait_n; i++) begin
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      tick();
      check_eq("stall_req", {31'd0, mem_req}, 1);
      check_eq("stall_addr", {27'd0, mem_addr}, m_pc);
    end
    mem_ack   = 1'b1;
    mem_rdata = w;
    tick();
    for (int ph = 0; ph < 2; ph++) begin
      mem_rdata = 16'($urandom);
      if (noise == 1) begin
        mem_ack = 1'b1;
        run     = 1'b1;
      end else if (noise == 2) begin
        mem_ack = 1'($urandom_range(0, 1));
        run     = 1'($urandom_range(0, 1));
      end else begin
        mem_ack = 1'b0;
        run     = 1'b0;
      end
      flag_z = (ph == 1) ? fz : 1'($urandom_range(0, 1));
      check_eq(ph == 0 ? "dec_req" : "exe_req", {31'd0, mem_req}, 0);
      check_eq(ph == 0 ? "dec_busy" : "exe_busy", {31'd0, busy}, 1);
      check_eq(ph == 0 ? "dec_code" : "exe_code", {28'd0, instr_code}, w[11:8]);
      check_eq(ph == 0 ? "dec_imm" : "exe_imm", {24'd0, imm_data}, w[7:0]);
      check_eq(ph == 0 ? "dec_oe" : "exe_oe", {30'd0, R1_oe, R0_oe}, w[13:12]);
      check_eq(ph == 0 ? "dec_pulses" : "exe_pulses",
               {27'd0, load_en, store_en, R0_ce, R1_ce, alu_en},
               ph == 0 ? 5'b00000 : exp_pulses(w));
      tick();
    end
    mem_ack = 1'b0;
    run     = 1'b0;
    if (w[11:8] == 4'hB && (w[13:12] == 2'b00 || w[13:12] == 2'b11)) m_err = 1'b1;
    m_halted = (w[11:8] == 4'hF);
    m_pc     = next_pc(w, m_pc, fz);
    check_eq("post_pc", {27'd0, pc}, m_pc);
    check_eq("post_err", {31'd0, err}, m_err);
    check_eq("post_halted", {31'd0, halted}, m_halted);
    check_eq("post_req", {31'd0, mem_req}, !m_halted);
    check_eq("post_pulses", {27'd0, load_en, store_en, R0_ce, R1_ce, alu_en}, 0);
  endtask

  task automatic do_run();
    run = 1'b1;
    tick();
    run = 1'b0;
    if (m_halted) m_pc = 0;
    m_halted = 1'b0;
  endtask

  task automatic halt_idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      tick();
      check_eq("halt_hold", {30'd0, halted, busy}, 2'b10);
      check_eq("halt_pc", {27'd0, pc}, m_pc);
      check_eq("halt_pulses", {27'd0, load_en, store_en, R0_ce, R1_ce, alu_en}, 0);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0; flag_z = 1'b0;
    for (int a = 0; a < DEPTH; a++) prog[a] = 16'h0C00;
    m_pc = 0; m_err = 1'b0; m_halted = 1'b0;
    tick();
    tick();
    check_eq("rst_outs_a", {7'd0, mem_req, mem_addr, instr_code, imm_data, pc, busy, halted, err}, 0);
    check_eq("rst_outs_b", {25'd0, load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe, alu_en}, 0);
    rst = 1'b0;
    tick();
    check_eq("idle_hold", {30'd0, busy, mem_req}, 0);

    // LOAD 0x05, STORE R0, NOP, then an ALU op with a 4-cycle fetch stall
    prog[0] = 16'h0A05; prog[1] = 16'h1B00; prog[2] = 16'h0C00; prog[3] = 16'h0312;
    do_run();
    exec_instr(0, 1'b0, 0);
    exec_instr(0, 1'b0, 0);
    exec_instr(0, 1'b0, 0);
    check_eq("pc_after_three", {27'd0, pc}, 3);
    exec_instr(4, 1'b0, 0);

    // JZ taken, JZ not taken, JMP 31, NOP wraps to 0
    prog[4] = 16'h0E10; prog[16] = 16'h0E05; prog[17] = 16'h0D1F; prog[31] = 16'h0C00;
    exec_instr(0, 1'b1, 0);
    check_eq("jz_taken_pc", {27'd0, pc}, 16);
    exec_instr(1, 1'b0, 0);
    exec_instr(0, 1'b0, 0);
    exec_instr(2, 1'b0, 0);
    check_eq("wrap_pc", {27'd0, pc}, 0);

    // illegal STORE, legal STORE R1, JMP 7, HALT at 7 with run held while busy
    prog[0] = 16'h3B00; prog[1] = 16'h2B00; prog[2] = 16'h0D07; prog[7] = 16'h0F00;
    exec_instr(0, 1'b0, 0);
    check_eq("err_set", {31'd0, err}, 1);
    exec_instr(0, 1'b0, 1);
    exec_instr(0, 1'b0, 1);
    exec_instr(3, 1'b0, 1);
    check_eq("halt_at_7", {26'd0, halted, pc}, {1'b1, 5'd7});
    halt_idle(3);
    do_run();
    check_eq("restart_fetch", {26'd0, mem_req, mem_addr}, {1'b1, 5'd0});

    // reset in the middle of a fetch
    mem_ack = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("rst_mid_fetch", {24'd0, mem_req, busy, halted, err, pc}, 0);
    rst = 1'b0;
    m_pc = 0; m_err = 1'b0; m_halted = 1'b0;
    tick();
    check_eq("idle_after_rst", {31'd0, mem_req}, 0);

    // random programs
    for (int a = 0; a < DEPTH; a++) prog[a] = 16'($urandom);
    do_run();
    for (int k = 0; k < 300; k++) begin
      bit fz;
      fz = 1'($urandom_range(0, 1));
      exec_instr($urandom_range(0, 3), fz, 2);
      if (m_halted) begin
        halt_idle($urandom_range(1, 3));
        do_run();
      end
      if (k == 150) for (int a = 0; a < DEPTH; a++) prog[a] = 16'($urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
